// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider: FSM encoding, handshake levels
// and the pipeline-wide reset/stall/zero constants.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

  localparam logic        RstEnable         = 1'b1;
  localparam logic        Stop              = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  localparam logic [5:0]  DivIters          = 6'd32;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: 32 iteration cycles, stall request
// while busy, {remainder, quotient} held until EX drops start_i.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  r_state;
  div_state_e  w_next_state;
  logic [5:0]  r_cnt;
  logic        r_need_low;
  logic [31:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic        r_signed;
  logic        r_dvd_neg;
  logic        r_dvs_neg;
  logic [32:0] w_trial;
  logic        w_start;

  function automatic logic [31:0] magnitude(input logic [31:0] val, input logic is_signed);
    magnitude = (is_signed && val[31]) ? -val : val;
  endfunction

  function automatic logic [63:0] fix_sign(input logic [31:0] quo, input logic [31:0] rem,
                                           input logic is_signed, input logic dvd_neg,
                                           input logic dvs_neg);
    logic [31:0] q;
    logic [31:0] r;
    q = (is_signed && (dvd_neg ^ dvs_neg)) ? -quo : quo;
    r = (is_signed && dvd_neg) ? -rem : rem;
    fix_sign = {r, q};
  endfunction

  // A start still held after leaving a division must be seen low before it counts again.
  assign w_start    = (start_i == DivStart) && !annul_i && !r_need_low;
  assign stallreq_o = (start_i && !ready_o && !annul_i) ? Stop : ~Stop;

  // Remainder is always below the divisor, so 2*rem+1 - divisor fits 33-bit signed.
  assign w_trial = {r_rem, r_dvd[31]} - {1'b0, r_dvs};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DivFree: begin
        if (w_start) w_next_state = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      end
      DivByZero: w_next_state = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)                w_next_state = DivFree;
        else if (r_cnt == DivIters) w_next_state = DivEnd;
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) w_next_state = DivFree;
      end
      default: w_next_state = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_need_low <= 1'b0;
      ready_o    <= DivResultNotReady;
      result_o   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state != DivFree && w_next_state == DivFree) r_need_low <= start_i;
      else if (start_i == DivStop)                       r_need_low <= 1'b0;

      case (r_state)
        DivFree: begin
          if (w_start) r_cnt <= '0;
        end
        DivByZero: begin
          if (w_next_state == DivEnd) begin
            ready_o  <= DivResultReady;
            result_o <= '0;
          end
        end
        DivOn: begin
          if (w_next_state == DivEnd) begin
            ready_o  <= DivResultReady;
            result_o <= fix_sign(r_dvd, r_rem, r_signed, r_dvd_neg, r_dvs_neg);
          end else if (w_next_state == DivOn) begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DivEnd: begin
          if (w_next_state == DivFree) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: dividend register shifts out into the remainder and
  // collects quotient bits at its LSB.
  always_ff @(posedge clk) begin
    if (r_state == DivFree && w_start) begin
      r_dvd     <= magnitude(opdata1_i, signed_div_i);
      r_dvs     <= magnitude(opdata2_i, signed_div_i);
      r_rem     <= '0;
      r_signed  <= signed_div_i;
      r_dvd_neg <= signed_div_i & opdata1_i[31];
      r_dvs_neg <= signed_div_i & opdata2_i[31];
    end else if (r_state == DivOn && w_next_state == DivOn) begin
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_dvd <= {r_dvd[30:0], 1'b1};
      end else begin
        r_rem <= {r_rem[30:0], r_dvd[31]};
        r_dvd <= {r_dvd[30:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: random and directed DIV/DIVU against a plain
// arithmetic model, plus annul, reset and handshake boundary cases.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready),
    .stallreq_o  (stallreq)
  );

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'h0) return 64'h0;
    if (!sg) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %h expected no result", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
    prev_ready = ready;
  end

  // Entered and left just after a rising edge with start low and DUT idle.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lowc;
    int          stc;
    int          exp_lat;
    logic [63:0] e;
    e = model(sg, a, b);
    exp_lat = (b == 32'h0) ? 2 : 34;
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    exp_q.push_back(e);
    lowc = 0;
    stc  = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) break;
      lowc++;
      if (stallreq) stc++;
      if (lowc == 2) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sg;
      end
    end
    check("latency", 64'(lowc), 64'(exp_lat));
    check("stall_cycles", 64'(stc), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("ready_clear", 64'(ready), 64'd0);
    check("result_clear", result, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        seen;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1;
    start = 1'b1;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    #12;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'h0);
    check("reset_stallreq_hi", 64'(stallreq), 64'd1);
    start = 1'b0;
    #1;
    check("reset_stallreq_lo", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, -32'sd7, 32'd2, 1);
    run_div(1'b1, 32'd7, -32'sd2, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'd1000, 32'd3, 3);

    // annul at cnt = 10, then a fresh start
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("annul_stallreq", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 annul = 1'b0; start = 1'b0;
    check("annul_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd1000, 32'd7, 0);

    // annul coinciding with the final iteration
    signed_div = 1'b1; op1 = -32'sd99; op2 = 32'd4; start = 1'b1;
    repeat (33) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0; start = 1'b0;
    check("annul_last_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    run_div(1'b1, -32'sd99, 32'd4, 0);

    // annul in DivEnd with start still high: no restart until start seen low
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    exp_q.push_back(model(1'b0, 32'd50, 32'd5));
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    check("end_annul_ready", 64'(ready), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    check("no_restart", 64'(seen), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd50, 32'd5, 0);

    // asynchronous reset mid-iteration
    signed_div = 1'b0; op1 = 32'd123456; op2 = 32'd789; start = 1'b1;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_on_ready", 64'(ready), 64'd0);
    check("rst_on_result", result, 64'h0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd123456, 32'd789, 0);

    // asynchronous reset while a result is held
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd9; start = 1'b1;
    exp_q.push_back(model(1'b0, 32'd77, 32'd9));
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(ready), 64'd0);
    check("rst_end_result", result, 64'h0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        4: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(sg, a, b, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
